cci_mpf_csr_event_ctrl: RTL

//  Event-counter controller behind the MPF CSR manager. Sums one-cycle event

---
 rtl/cci_mpf_csr_event_ctrl_if.sv | 24 ++
 rtl/cci_mpf_csr_event_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cci_mpf_csr_event_ctrl_if.sv
// MMIO counter-read request/response bundle between the CSR manager and the
// event controller.
interface cci_mpf_csr_event_ctrl_if #(
    parameter int TID_WIDTH = 9
);
    logic                 rd_req_valid;
    logic [4:0]           rd_req_idx;
    logic [TID_WIDTH-1:0] rd_req_tid;
    logic                 rd_req_full;
    logic                 rd_rsp_valid;
    logic [63:0]          rd_rsp_data;
    logic [TID_WIDTH-1:0] rd_rsp_tid;
    logic                 rd_rsp_ready;

    modport master (
        output rd_req_valid, rd_req_idx, rd_req_tid, rd_rsp_ready,
        input  rd_req_full, rd_rsp_valid, rd_rsp_data, rd_rsp_tid
    );

    modport slave (
        input  rd_req_valid, rd_req_idx, rd_req_tid, rd_rsp_ready,
        output rd_req_full, rd_rsp_valid, rd_rsp_data, rd_rsp_tid
    );
endinterface

// File: rtl/cci_mpf_csr_event_ctrl.sv
// Per-event counters with CSR clear, and a queued MMIO read path that
// snapshots a counter and returns it through a valid/ready response.
module cci_mpf_csr_event_ctrl #(
    parameter int N_EVENTS       = 13,
    parameter int CNT_WIDTH      = 48,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int TID_WIDTH      = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_EVENTS-1:0]  evt_in,
    cci_mpf_csr_event_ctrl_if.slave rd,
    input  logic                 clr_valid,
    input  logic [4:0]           clr_idx,
    input  logic                 clr_all,
    output logic                 overflow_err
);
    localparam int PTR_W   = $clog2(REQ_FIFO_DEPTH);
    localparam int ENTRY_W = 5 + TID_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_RSP} state_t;

    logic [CNT_WIDTH-1:0] cnt     [N_EVENTS];
    logic [CNT_WIDTH-1:0] cnt_nxt [N_EVENTS];

    logic [ENTRY_W-1:0]   q_mem [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       q_count;
    logic                 enq;
    logic                 deq;

    state_t               state;
    state_t               state_nxt;
    logic [4:0]           snap_idx;
    logic [TID_WIDTH-1:0] snap_tid;
    logic [CNT_WIDTH-1:0] snap_val;
    logic [63:0]          rsp_data;
    logic [TID_WIDTH-1:0] rsp_tid;

    // Clear takes priority over a same-cycle event; out-of-range clr_idx never matches.
    always_comb begin
        for (int unsigned i = 0; i < N_EVENTS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr_all || (clr_valid && (clr_idx == 5'(i))))
                cnt_nxt[i] = '0;
            else if (evt_in[i])
                cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_EVENTS; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_EVENTS; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    assign rd.rd_req_full = (q_count == (PTR_W+1)'(REQ_FIFO_DEPTH));
    assign enq            = rd.rd_req_valid && !rd.rd_req_full;

    always_ff @(posedge clk) begin
        if (enq)
            q_mem[wr_ptr] <= {rd.rd_req_idx, rd.rd_req_tid};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_count      <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   q_count <= q_count + (PTR_W+1)'(1);
                2'b01:   q_count <= q_count - (PTR_W+1)'(1);
                default: q_count <= q_count;
            endcase
            if (rd.rd_req_valid && rd.rd_req_full)
                overflow_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        deq       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (q_count != '0) begin
                    deq       = 1'b1;
                    state_nxt = ST_SNAP;
                end
            end
            ST_SNAP: state_nxt = ST_RSP;
            ST_RSP:  if (rd.rd_rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot the next-state value so increments/clears landing on the SNAP edge are included.
    always_comb begin
        snap_val = '0;
        for (int unsigned i = 0; i < N_EVENTS; i++)
            if (snap_idx == 5'(i))
                snap_val = cnt_nxt[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            snap_idx <= '0;
            snap_tid <= '0;
            rsp_data <= '0;
            rsp_tid  <= '0;
        end else begin
            state <= state_nxt;
            if (deq)
                {snap_idx, snap_tid} <= q_mem[rd_ptr];
            if (state == ST_SNAP) begin
                rsp_data <= 64'(snap_val);
                rsp_tid  <= snap_tid;
            end
        end
    end

    assign rd.rd_rsp_valid = (state == ST_RSP);
    assign rd.rd_rsp_data  = rsp_data;
    assign rd.rd_rsp_tid   = rsp_tid;
endmodule
